fpga_boot_reset_sequencer: RTL and testbench
============================================

# fpga_boot_reset_sequencer

FPGA-top sequencer between the board-level clock wizard, reset button, and strap pins and the `x_heep_system` instance. It holds the SoC in reset until the clock wizard reports lock, debounces the reset button, and applies a fixed reset hold time. At reset release it freezes the boot straps, then monitors `exit_valid` to capture the program exit value. It also drives a status LED that encodes the sequencing phase and the pass/fail result.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required to accept a button level change; must be ≥1.
- `RESET_HOLD_CYCLES`, default 64: cycles the SoC reset is held after lock or button press; must be ≥1.
- `BLINK_LEN`, default 27: width of the free-running LED counter; must be ≥3.

Ports:
- `clk_i` in 1: fabric clock, the clock-wizard output.
- `rst_i` in 1: synchronous, active-high reset of this block.
- `clk_locked_i` in 1: clock-wizard lock; asynchronous, 2-flop synchronized internally.
- `btn_rst_i` in 1: raw reset button, active-high; asynchronous, 2-flop synchronized internally.
- `boot_select_pad_i` in 1: boot-select strap pin; asynchronous, 2-flop synchronized.
- `execute_from_flash_pad_i` in 1: execute-from-flash strap pin; asynchronous, 2-flop synchronized.
- `exit_valid_i` in 1: SoC exit valid, in the `clk_i` domain.
- `exit_value_i` in 32: SoC exit value.
- `soc_rst_no` out 1: active-low reset to the SoC.
- `boot_select_o` out 1: frozen boot-select strap to the SoC.
- `execute_from_flash_o` out 1: frozen execute-from-flash strap to the SoC.
- `exit_value_o` out 32: captured exit value.
- `done_o` out 1: exit value has been captured.
- `pass_o` out 1: captured value == 0.
- `status_led_o` out 1: status LED.
- `state_o` out 2: FSM state for debug. Encoding: 0 WAIT_LOCK, 1 HOLD, 2 RUN, 3 DONE.

## Operation
- **Synchronizers.** `lock_s`, `btn_s`, `bs_s`, and `eff_s` are 2-flop synchronized versions of their inputs. All synchronizer flops reset to 0.
- **Debouncer.**
  - Holds a debounced level `btn_db` and a counter `db_cnt`.
  - If `btn_s == btn_db`, `db_cnt` is cleared.
  - Otherwise `db_cnt` increments. When it reaches `DEBOUNCE_CYCLES-1`, `btn_db` toggles and `db_cnt` clears.
  - `press` is a one-cycle pulse on the rising edge of `btn_db`. Release generates no event.
- **FSM.** State register plus hold counter `hold_cnt`. Priority per cycle: lock loss > press > normal transition.
  - Any state, `lock_s == 0`: go to WAIT_LOCK.
  - Any state, `lock_s == 1` and `press`: go to HOLD and clear `hold_cnt`.
  - WAIT_LOCK: when `lock_s == 1`, go to HOLD with `hold_cnt = 0`.
  - HOLD: `hold_cnt` increments each cycle. When `hold_cnt == RESET_HOLD_CYCLES-1`, go to RUN. On that same edge, latch `bs_s` / `eff_s` into `boot_select_o` / `execute_from_flash_o`.
  - RUN: when `exit_valid_i == 1`, go to DONE. On that same edge, latch `exit_value_i` into `exit_value_o`, set `done_o = 1`, and set `pass_o = (exit_value_i == 0)`.
  - DONE: terminal until a lock loss or a press. Further `exit_valid_i` pulses are ignored and the captured value is held.
- **Output decode.**
  - `soc_rst_no` = 1 only in RUN or DONE, decoded from the state register with no combinational path from any input.
  - Entering WAIT_LOCK or HOLD clears `done_o`, `pass_o`, and `exit_value_o`.
  - Straps keep their last frozen value until the next HOLD→RUN transition.
- **LED.** `led_cnt` (`BLINK_LEN` bits) is free-running and wraps to 0.
  - WAIT_LOCK: LED = 0.
  - HOLD: LED = 1.
  - RUN: LED = `led_cnt[BLINK_LEN-1]`.
  - DONE with pass: LED = 1.
  - DONE with fail: LED = `led_cnt[BLINK_LEN-3]` (fast blink).
  - `status_led_o` is registered.

## Timing
- **Reset values** (while `rst_i` is high): state WAIT_LOCK, `soc_rst_no` 0, straps 0, `exit_value_o` 0, `done_o` 0, `pass_o` 0, `status_led_o` 0, `state_o` 0, all counters 0.
- **Lock to reset release.** `clk_locked_i` first sampled high at edge t gives `state_o == HOLD` after edge t+3. `soc_rst_no` rises after edge t+3+`RESET_HOLD_CYCLES`.
- **Lock loss.** `clk_locked_i` sampled low at edge t gives `soc_rst_no == 0` after edge t+3.
- **Button press.**
  - Minimum press-to-HOLD latency is 2 synchronizer + `DEBOUNCE_CYCLES` + 1 FSM cycles.
  - A glitch shorter than `DEBOUNCE_CYCLES` stable cycles produces no event.
- **Exit capture.** `exit_valid_i` high at edge t while in RUN gives `done_o`, `pass_o`, and `exit_value_o` valid after edge t. `exit_valid_i` is not registered beforehand.
- **Simultaneous events.**
  - Press and `exit_valid_i` in the same RUN cycle: press wins and nothing is captured.
  - Lock loss and press in the same cycle: the FSM goes to WAIT_LOCK.
- **Counter wraps.** `led_cnt` wraps silently. `hold_cnt` never exceeds `RESET_HOLD_CYCLES-1`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `RESET_HOLD_CYCLES`=8, `BLINK_LEN`=4.
- **Power-up.** `rst_i` held 5 cycles, then released, then `clk_locked_i` raised at edge 0 → `state_o` = 1 after edge 3, `soc_rst_no` = 1 after edge 11. All outputs stay 0 before that.
- **Strap freeze.** `boot_select_pad_i` = 1 and `execute_from_flash_pad_i` = 1 during HOLD, both toggled to 0 in RUN → `boot_select_o` and `execute_from_flash_o` remain 1.
- **Exit capture.**
  - `exit_valid_i` pulse with `exit_value_i` = 0 → `done_o` = 1, `pass_o` = 1, LED steady 1.
  - Repeat from reset with value 0x0000_0005 → `pass_o` = 0 and the LED toggles every 2 cycles.
  - A second pulse with value 7 → `exit_value_o` stays 5.
- **Debounce.**
  - `btn_rst_i` high for 3 cycles → no state change.
  - `btn_rst_i` high for 10 cycles in DONE → HOLD entered, `soc_rst_no` = 0, `done_o` = 0, `exit_value_o` = 0. After 8 cycles the FSM returns to RUN.
- **Lock loss mid-run.** `clk_locked_i` dropped in RUN → `state_o` = 0 and `soc_rst_no` = 0 three cycles later. Re-lock → full 8-cycle hold before release.
- **Simultaneous events.** Debounced press and `exit_valid_i` in the same RUN cycle → HOLD, `done_o` stays 0.

Source files
------------

// File: rtl/fpga_boot_reset_sequencer.sv
// Boot/reset sequencer between the clock wizard, reset button, strap pins and the SoC.
// Holds the SoC in reset until lock plus a fixed hold time, freezes straps, captures the exit value.
module fpga_boot_reset_sequencer #(
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter int RESET_HOLD_CYCLES = 64,
    parameter int BLINK_LEN         = 27
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clk_locked_i,
    input  logic        btn_rst_i,
    input  logic        boot_select_pad_i,
    input  logic        execute_from_flash_pad_i,
    input  logic        exit_valid_i,
    input  logic [31:0] exit_value_i,
    output logic        soc_rst_no,
    output logic        boot_select_o,
    output logic        execute_from_flash_o,
    output logic [31:0] exit_value_o,
    output logic        done_o,
    output logic        pass_o,
    output logic        status_led_o,
    output logic [1:0]  state_o
);

    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_HOLD      = 2'd1,
        S_RUN       = 2'd2,
        S_DONE      = 2'd3
    } state_e;

    logic [1:0] lock_sync_q, btn_sync_q, bs_sync_q, eff_sync_q;
    logic       lock_s, btn_s, bs_s, eff_s;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_sync_q <= '0;
            btn_sync_q  <= '0;
            bs_sync_q   <= '0;
            eff_sync_q  <= '0;
        end else begin
            lock_sync_q <= {lock_sync_q[0], clk_locked_i};
            btn_sync_q  <= {btn_sync_q[0], btn_rst_i};
            bs_sync_q   <= {bs_sync_q[0], boot_select_pad_i};
            eff_sync_q  <= {eff_sync_q[0], execute_from_flash_pad_i};
        end
    end

    assign lock_s = lock_sync_q[1];
    assign btn_s  = btn_sync_q[1];
    assign bs_s   = bs_sync_q[1];
    assign eff_s  = eff_sync_q[1];

    // Debouncer: the level flips only after DEBOUNCE_CYCLES consecutive mismatching samples.
    logic            btn_db_q, btn_db_d, btn_db_prev_q;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            press;

    always_comb begin
        btn_db_d = btn_db_q;
        db_cnt_d = '0;
        if (btn_s != btn_db_q) begin
            if (db_cnt_q == DB_LAST) begin
                btn_db_d = ~btn_db_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            btn_db_q      <= 1'b0;
            btn_db_prev_q <= 1'b0;
            db_cnt_q      <= '0;
        end else begin
            btn_db_q      <= btn_db_d;
            btn_db_prev_q <= btn_db_q;
            db_cnt_q      <= db_cnt_d;
        end
    end

    assign press = btn_db_q & ~btn_db_prev_q;

    state_e              state_q, state_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic                freeze, capture, clear;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_WAIT_LOCK;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // Lock loss beats a press, a press beats the normal transition.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = '0;
        freeze     = 1'b0;
        capture    = 1'b0;
        if (!lock_s) begin
            state_d = S_WAIT_LOCK;
        end else if (press) begin
            state_d = S_HOLD;
        end else begin
            unique case (state_q)
                S_WAIT_LOCK: state_d = S_HOLD;
                S_HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d = S_RUN;
                        freeze  = 1'b1;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
                S_RUN: begin
                    if (exit_valid_i) begin
                        state_d = S_DONE;
                        capture = 1'b1;
                    end
                end
                S_DONE: state_d = S_DONE;
                default: state_d = S_WAIT_LOCK;
            endcase
        end
        clear = (state_d == S_WAIT_LOCK) || (state_d == S_HOLD);
    end

    logic [BLINK_LEN-1:0] led_cnt_q;
    logic                 led_d, led_q;

    always_comb begin
        soc_rst_no = (state_q == S_RUN) || (state_q == S_DONE);
        unique case (state_q)
            S_WAIT_LOCK: led_d = 1'b0;
            S_HOLD:      led_d = 1'b1;
            S_RUN:       led_d = led_cnt_q[BLINK_LEN-1];
            S_DONE:      led_d = pass_o ? 1'b1 : led_cnt_q[BLINK_LEN-3];
            default:     led_d = 1'b0;
        endcase
    end

    logic        bs_q, eff_q, done_q, pass_q;
    logic [31:0] exit_value_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            led_cnt_q    <= '0;
            led_q        <= 1'b0;
            bs_q         <= 1'b0;
            eff_q        <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            exit_value_q <= '0;
        end else begin
            led_cnt_q <= led_cnt_q + BLINK_LEN'(1);
            led_q     <= led_d;
            if (freeze) begin
                bs_q  <= bs_s;
                eff_q <= eff_s;
            end
            if (clear) begin
                done_q       <= 1'b0;
                pass_q       <= 1'b0;
                exit_value_q <= '0;
            end else if (capture) begin
                done_q       <= 1'b1;
                pass_q       <= (exit_value_i == 32'd0);
                exit_value_q <= exit_value_i;
            end
        end
    end

    assign boot_select_o        = bs_q;
    assign execute_from_flash_o = eff_q;
    assign exit_value_o         = exit_value_q;
    assign done_o               = done_q;
    assign pass_o               = pass_q;
    assign status_led_o         = led_q;
    assign state_o              = state_q;

endmodule

// File: tb/tb_fpga_boot_reset_sequencer.sv
// Bench for fpga_boot_reset_sequencer: directed scenarios plus random stimulus
// against a behavioural model of the sequencing rules.
module tb_fpga_boot_reset_sequencer;

    localparam int D = 4;
    localparam int H = 8;
    localparam int B = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        clk_locked_i = 1'b0;
    logic        btn_rst_i = 1'b0;
    logic        boot_select_pad_i = 1'b0;
    logic        execute_from_flash_pad_i = 1'b0;
    logic        exit_valid_i = 1'b0;
    logic [31:0] exit_value_i = '0;
    logic        soc_rst_no, boot_select_o, execute_from_flash_o, done_o, pass_o, status_led_o;
    logic [31:0] exit_value_o;
    logic [1:0]  state_o;

    int checks = 0;
    int errors = 0;

    fpga_boot_reset_sequencer #(
        .DEBOUNCE_CYCLES(D), .RESET_HOLD_CYCLES(H), .BLINK_LEN(B)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clk_locked_i(clk_locked_i), .btn_rst_i(btn_rst_i),
        .boot_select_pad_i(boot_select_pad_i), .execute_from_flash_pad_i(execute_from_flash_pad_i),
        .exit_valid_i(exit_valid_i), .exit_value_i(exit_value_i), .soc_rst_no(soc_rst_no),
        .boot_select_o(boot_select_o), .execute_from_flash_o(execute_from_flash_o),
        .exit_value_o(exit_value_o), .done_o(done_o), .pass_o(pass_o),
        .status_led_o(status_led_o), .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural model: input histories for the synchronizers, a run-length for the debouncer.
    int          m_state, m_hold, m_run, m_cnt;
    bit [1:0]    m_lock_h, m_btn_h, m_bs_h, m_eff_h;
    bit          m_db, m_db_prev, m_bs, m_eff, m_done, m_pass, m_led;
    logic [31:0] m_exit;

    function automatic void m_step();
        bit press, cap, frz, old_db;
        int ns;
        if (rst_i) begin
            m_state = 0; m_hold = 0; m_run = 0; m_cnt = 0;
            m_lock_h = 0; m_btn_h = 0; m_bs_h = 0; m_eff_h = 0;
            m_db = 0; m_db_prev = 0; m_bs = 0; m_eff = 0;
            m_done = 0; m_pass = 0; m_led = 0; m_exit = 0;
            return;
        end
        press = m_db && !m_db_prev;
        ns = m_state; cap = 0; frz = 0;
        if (!m_lock_h[1]) ns = 0;
        else if (press) begin ns = 1; m_hold = 0; end
        else if (m_state == 0) begin ns = 1; m_hold = 0; end
        else if (m_state == 1) begin
            if (m_hold == H - 1) begin ns = 2; frz = 1; end
            else m_hold++;
        end else if (m_state == 2 && exit_valid_i) begin ns = 3; cap = 1; end
        case (m_state)
            0: m_led = 0;
            1: m_led = 1;
            2: m_led = ((m_cnt >> (B - 1)) & 1) != 0;
            default: m_led = m_pass ? 1'b1 : (((m_cnt >> (B - 3)) & 1) != 0);
        endcase
        m_cnt = (m_cnt + 1) % (1 << B);
        if (frz) begin m_bs = m_bs_h[1]; m_eff = m_eff_h[1]; end
        if (ns <= 1) begin m_done = 0; m_pass = 0; m_exit = 0; end
        else if (cap) begin m_done = 1; m_pass = (exit_value_i == 0); m_exit = exit_value_i; end
        m_state = ns;
        old_db = m_db;
        if (m_btn_h[1] != m_db) begin
            m_run++;
            if (m_run == D) begin m_db = !m_db; m_run = 0; end
        end else m_run = 0;
        m_db_prev = old_db;
        m_lock_h = {m_lock_h[0], clk_locked_i};
        m_btn_h  = {m_btn_h[0], btn_rst_i};
        m_bs_h   = {m_bs_h[0], boot_select_pad_i};
        m_eff_h  = {m_eff_h[0], execute_from_flash_pad_i};
    endfunction

    function automatic logic [39:0] m_vec();
        return {m_state[1:0], ~(m_state < 2), m_bs, m_eff, m_done, m_pass, m_led, m_exit};
    endfunction

    function automatic logic [39:0] dut_vec();
        return {state_o, soc_rst_no, boot_select_o, execute_from_flash_o, done_o, pass_o,
                status_led_o, exit_value_o};
    endfunction

    // Advance one clock: model consumes the inputs applied before the edge; sample 1ns after.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            m_step();
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1; clk_locked_i = 0; btn_rst_i = 0; exit_valid_i = 0; exit_value_i = 0;
        boot_select_pad_i = 0; execute_from_flash_pad_i = 0;
        tick(5);
        rst_i = 1'b0;
    endtask

    task automatic bring_up();
        do_reset();
        clk_locked_i = 1'b1;
        tick(12);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (dut_vec() !== 40'd0) begin
            errors++; $display("FAIL reset: got %h want 0", dut_vec());
        end
    endtask

    task automatic test_power_up();
        int bad = 0;
        clk_locked_i = 1'b1;
        tick(2);
        checks++;
        if (state_o !== 2'd0) begin errors++; $display("FAIL pu_state_e2: got %0d want 0", state_o); end
        tick(1);
        checks++;
        if (state_o !== 2'd1) begin errors++; $display("FAIL pu_state_e3: got %0d want 1", state_o); end
        for (int i = 4; i <= 10; i++) begin
            tick(1);
            if (soc_rst_no !== 1'b0 || done_o !== 1'b0 || exit_value_o !== 0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL pu_hold_outputs: got %0d bad cycles want 0", bad); end
        tick(1);
        checks++;
        if (soc_rst_no !== 1'b1 || state_o !== 2'd2) begin
            errors++; $display("FAIL pu_release_e11: got rst_n=%b st=%0d want 1/2", soc_rst_no, state_o);
        end
    endtask

    task automatic test_strap_freeze();
        do_reset();
        clk_locked_i = 1'b1; boot_select_pad_i = 1'b1; execute_from_flash_pad_i = 1'b1;
        tick(12);
        boot_select_pad_i = 1'b0; execute_from_flash_pad_i = 1'b0;
        tick(6);
        checks++;
        if (boot_select_o !== 1'b1 || execute_from_flash_o !== 1'b1) begin
            errors++; $display("FAIL strap_freeze: got %b%b want 11", boot_select_o, execute_from_flash_o);
        end
    endtask

    task automatic test_exit_pass();
        int bad = 0;
        bring_up();
        exit_valid_i = 1'b1; exit_value_i = 32'd0;
        tick(1);
        exit_valid_i = 1'b0; exit_value_i = 32'hdead_beef;
        checks++;
        if (done_o !== 1'b1 || pass_o !== 1'b1 || exit_value_o !== 32'd0) begin
            errors++; $display("FAIL exit_pass: got d=%b p=%b v=%h want 1/1/0", done_o, pass_o, exit_value_o);
        end
        tick(1);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (status_led_o !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL led_pass_steady: got %0d low cycles want 0", bad); end
    endtask

    task automatic test_exit_fail();
        logic led_s [12];
        int bad = 0;
        bring_up();
        exit_valid_i = 1'b1; exit_value_i = 32'd5;
        tick(1);
        exit_valid_i = 1'b0;
        checks++;
        if (done_o !== 1'b1 || pass_o !== 1'b0 || exit_value_o !== 32'd5) begin
            errors++; $display("FAIL exit_fail: got d=%b p=%b v=%h want 1/0/5", done_o, pass_o, exit_value_o);
        end
        tick(1);
        for (int i = 0; i < 12; i++) begin
            tick(1);
            led_s[i] = status_led_o;
        end
        for (int i = 0; i < 10; i++) if (led_s[i] === led_s[i+2] || led_s[i] === 1'bx) bad++;
        for (int i = 0; i < 11; i += 2) if (led_s[i] !== led_s[i+1]) bad++;
        if (led_s[0] === led_s[1]) begin
            // phase aligned to pairs (0,1); otherwise check pairs (1,2)
        end
        checks++;
        if (bad != 0 && !(led_s[1] === led_s[2] && led_s[3] === led_s[4] && led_s[0] !== led_s[2])) begin
            errors++; $display("FAIL led_fail_blink: got %0d period violations want 0", bad);
        end
        checks++;
        if (status_led_o !== m_led) begin errors++; $display("FAIL led_fail_model: got %b want %b", status_led_o, m_led); end
        exit_valid_i = 1'b1; exit_value_i = 32'd7;
        tick(1);
        exit_valid_i = 1'b0;
        tick(1);
        checks++;
        if (exit_value_o !== 32'd5 || done_o !== 1'b1 || state_o !== 2'd3) begin
            errors++; $display("FAIL exit_hold: got v=%h st=%0d want 5/3", exit_value_o, state_o);
        end
    endtask

    task automatic test_debounce();
        int bad = 0;
        btn_rst_i = 1'b1;
        tick(3);
        btn_rst_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (state_o !== 2'd3) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL debounce_glitch: got %0d non-DONE cycles want 0", bad); end
        btn_rst_i = 1'b1;
        tick(6);
        checks++;
        if (state_o !== 2'd3) begin errors++; $display("FAIL press_early: got %0d want 3", state_o); end
        tick(1);
        checks++;
        if (state_o !== 2'd1 || soc_rst_no !== 1'b0 || done_o !== 1'b0 || exit_value_o !== 0) begin
            errors++; $display("FAIL press_hold: got st=%0d rst_n=%b d=%b v=%h want 1/0/0/0",
                                state_o, soc_rst_no, done_o, exit_value_o);
        end
        tick(3);
        btn_rst_i = 1'b0;
        tick(4);
        checks++;
        if (state_o !== 2'd1) begin errors++; $display("FAIL press_hold_len: got %0d want 1", state_o); end
        tick(1);
        checks++;
        if (state_o !== 2'd2 || soc_rst_no !== 1'b1) begin
            errors++; $display("FAIL press_rerun: got st=%0d rst_n=%b want 2/1", state_o, soc_rst_no);
        end
    endtask

    task automatic test_lock_loss();
        bring_up();
        clk_locked_i = 1'b0;
        tick(2);
        checks++;
        if (soc_rst_no !== 1'b1) begin errors++; $display("FAIL lock_loss_early: got %b want 1", soc_rst_no); end
        tick(1);
        checks++;
        if (state_o !== 2'd0 || soc_rst_no !== 1'b0) begin
            errors++; $display("FAIL lock_loss: got st=%0d rst_n=%b want 0/0", state_o, soc_rst_no);
        end
        tick(3);
        clk_locked_i = 1'b1;
        tick(10);
        checks++;
        if (state_o !== 2'd1 || soc_rst_no !== 1'b0) begin
            errors++; $display("FAIL relock_hold: got st=%0d rst_n=%b want 1/0", state_o, soc_rst_no);
        end
        tick(1);
        checks++;
        if (soc_rst_no !== 1'b1) begin errors++; $display("FAIL relock_release: got %b want 1", soc_rst_no); end
    endtask

    task automatic test_simultaneous();
        bring_up();
        btn_rst_i = 1'b1;
        tick(6);
        exit_valid_i = 1'b1; exit_value_i = 32'd0;
        tick(1);
        exit_valid_i = 1'b0;
        btn_rst_i = 1'b0;
        checks++;
        if (state_o !== 2'd1 || done_o !== 1'b0 || exit_value_o !== 0) begin
            errors++; $display("FAIL press_vs_exit: got st=%0d d=%b want 1/0", state_o, done_o);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        bring_up();
        for (int i = 0; i < 4000; i++) begin
            rst_i = ($urandom_range(0, 799) == 0);
            if (clk_locked_i) clk_locked_i = ($urandom_range(0, 199) != 0);
            else clk_locked_i = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 5) == 0) btn_rst_i = ~btn_rst_i;
            if ($urandom_range(0, 9) == 0) boot_select_pad_i = ~boot_select_pad_i;
            if ($urandom_range(0, 9) == 0) execute_from_flash_pad_i = ~execute_from_flash_pad_i;
            exit_valid_i = ($urandom_range(0, 11) == 0);
            exit_value_i = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom);
            tick(1);
            checks++;
            if (dut_vec() !== m_vec()) begin
                errors++; bad++;
                if (bad <= 10) $display("FAIL random[%0d]: got %h want %h", i, dut_vec(), m_vec());
            end
        end
        rst_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_strap_freeze();
        test_exit_pass();
        test_exit_fail();
        test_debounce();
        test_lock_loss();
        test_simultaneous();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
